result_display: RTL and testbench

Downstream consumer of the data-memory result byte: it takes the 8-bit result the CPU writes into the result slot of the small data RAM and drives a multiplexed 4-digit common-anode seven-segment display. On a load strobe it latches the byte and converts it to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine. It then scans the digits continuously with a programmable refresh divider. It sits between the data RAM's write path and the board display pins.

---
 rtl/result_display.sv | 198 +++++++++++++++++++
 tb/tb_result_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// result_display: latches the CPU result byte, converts it to three BCD digits with a
// sequential double-dabble engine, and scans a 4-digit common-anode seven-segment display.
// Optional feature: define RESULT_DISPLAY_LZB_EN for leading-zero blanking of hundreds/tens.

module result_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] an
);

`ifdef RESULT_DISPLAY_LZB_EN
    localparam bit LzbEn = 1'b1;
`else
    localparam bit LzbEn = 1'b0;
`endif

    localparam logic [15:0] ScanLast = 16'(SCAN_DIV - 1);

    typedef enum logic {
        StIdle = 1'b0,
        StConv = 1'b1
    } state_e;

    state_e      r_state;
    state_e      w_state_next;

    logic [7:0]  r_sr;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_units;
    logic [15:0] r_scan_cnt;
    logic [1:0]  r_digit;
    logic [7:0]  r_seg;
    logic [3:0]  r_an;

    logic [11:0] w_bcd_adj;
    logic [11:0] w_bcd_shift;
    logic [7:0]  w_sr_shift;
    logic        w_last;
    logic        w_start;
    logic [3:0]  w_digit_val;
    logic        w_blank;
    logic [7:0]  w_seg_next;

    // Double-dabble step: add 3 to each nibble >= 5, then shift {bcd, sr} left by one.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
        w_bcd_shift = {w_bcd_adj[10:0], r_sr[7]};
        w_sr_shift  = {r_sr[6:0], 1'b0};
        w_last      = (r_state == StConv) && (r_cnt == 3'd7);
        // A load on the commit edge starts the next conversion directly, so back-to-back
        // results need no idle cycle in between.
        w_start     = load && ((r_state == StIdle) || w_last);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (load) w_state_next = StConv;
            StConv: if (w_last) w_state_next = load ? StConv : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state == StConv);
    end

    // Conversion datapath: capture on start, one shift-add-3 step per CONV cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr  <= 8'd0;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
        end else if (w_start) begin
            r_sr  <= value;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
        end else if (r_state == StConv) begin
            r_sr  <= w_sr_shift;
            r_bcd <= w_bcd_shift;
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Display register: only updated with the result of the final shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (w_last) begin
            r_hund  <= w_bcd_shift[11:8];
            r_tens  <= w_bcd_shift[7:4];
            r_units <= w_bcd_shift[3:0];
        end
    end

    // Refresh divider and digit index; free-running, independent of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= 16'd0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt == ScanLast) begin
            r_scan_cnt <= 16'd0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    // Select the digit to show and decide whether it is blanked.
    always_comb begin
        w_digit_val = 4'd0;
        w_blank     = 1'b1;
        unique case (r_digit)
            2'd0: begin
                w_digit_val = r_units;
                w_blank     = 1'b0;
            end
            2'd1: begin
                w_digit_val = r_tens;
                w_blank     = LzbEn && (r_hund == 4'd0) && (r_tens == 4'd0);
            end
            2'd2: begin
                w_digit_val = r_hund;
                w_blank     = LzbEn && (r_hund == 4'd0);
            end
            default: begin
                // Digit 3 is a dark slot kept only so every digit gets the same duty.
                w_digit_val = 4'd0;
                w_blank     = 1'b1;
            end
        endcase
    end

    // Active-low segment decode, dp always off.
    always_comb begin
        w_seg_next = 8'hFF;
        if (!w_blank) begin
            case (w_digit_val)
                4'd0:    w_seg_next = 8'hC0;
                4'd1:    w_seg_next = 8'hF9;
                4'd2:    w_seg_next = 8'hA4;
                4'd3:    w_seg_next = 8'hB0;
                4'd4:    w_seg_next = 8'h99;
                4'd5:    w_seg_next = 8'h92;
                4'd6:    w_seg_next = 8'h82;
                4'd7:    w_seg_next = 8'hF8;
                4'd8:    w_seg_next = 8'h80;
                4'd9:    w_seg_next = 8'h90;
                default: w_seg_next = 8'hFF;
            endcase
        end
    end

    // Registered pin drivers, one cycle behind the digit index and display register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'hC0;
            r_an  <= 4'b1110;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= ~(4'b0001 << r_digit);
        end
    end

    // Pin assignment.
    always_comb begin
        seg = r_seg;
        an  = r_an;
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed scenarios plus random loads, compared
// every cycle against a cycle-count based model of conversion timing and scan position.

module tb_result_display;

    localparam int unsigned Div = 4;

    logic       clk;
    logic       rst;
    logic [7:0] value;
    logic       load;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] an;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: edges since reset release, shown value, pending value, end of busy window.
    int edge_n     = 0;
    int m_disp     = 0;
    int m_pend     = 0;
    int m_busy_end = 0;

    logic [7:0] seg_codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    result_display #(
        .SCAN_DIV (Div)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .load  (load),
        .busy  (busy),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int dig, input int v);
        bit lzb;
`ifdef RESULT_DISPLAY_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        case (dig)
            0: return seg_codes[v % 10];
            1: return (lzb && v < 10) ? 8'hFF : seg_codes[(v / 10) % 10];
            2: return (lzb && v < 100) ? 8'hFF : seg_codes[v / 100];
            default: return 8'hFF;
        endcase
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare outputs.
    task automatic tick(input logic ld, input logic [7:0] v);
        int         shown;
        int         dig;
        logic [3:0] an_exp;
        load  = ld;
        value = v;
        @(posedge clk);
        edge_n++;
        shown = m_disp;
        if (edge_n == m_busy_end) m_disp = m_pend;
        if (ld && edge_n >= m_busy_end) begin
            m_pend     = int'(v);
            m_busy_end = edge_n + 8;
        end
        #1;
        dig        = ((edge_n - 1) / int'(Div)) % 4;
        an_exp     = 4'b1111;
        an_exp[dig] = 1'b0;
        check_eq("busy", 32'(busy), 32'(edge_n < m_busy_end));
        check_eq("an", 32'(an), 32'(an_exp));
        check_eq("seg", 32'(seg), 32'(exp_seg(dig, shown)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0);
    endtask

    // Asynchronous reset: outputs must snap to reset values before any clock edge.
    task automatic do_reset();
        rst  = 1'b0;
        load = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_an", 32'(an), 32'(4'b1110));
        check_eq("rst_seg", 32'(seg), 32'(8'hC0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst        = 1'b1;
        edge_n     = 0;
        m_disp     = 0;
        m_pend     = 0;
        m_busy_end = 0;
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 8'd0;
        #2;
        do_reset();

        // Reset scan pattern over two full rotations.
        idle(2 * 4 * Div);

        // Largest value.
        tick(1'b1, 8'd255);
        idle(8 + 4 * Div);

        // Load during conversion is dropped.
        tick(1'b1, 8'd7);
        idle(2);
        tick(1'b1, 8'd99);
        idle(6 + 4 * Div);

        // Back-to-back: second load on the commit edge.
        tick(1'b1, 8'd100);
        idle(7);
        tick(1'b1, 8'd42);
        idle(8 + 4 * Div);

        // Reset mid-conversion, then a clean conversion of the same value.
        tick(1'b1, 8'd200);
        idle(3);
        do_reset();
        idle(4 * Div);
        tick(1'b1, 8'd200);
        idle(8 + 4 * Div);

        // Values exercising leading-zero blanking.
        tick(1'b1, 8'd5);
        idle(8 + 4 * Div);
        tick(1'b1, 8'd50);
        idle(8 + 4 * Div);
        tick(1'b1, 8'd0);
        idle(8 + 4 * Div);

        // Random loads, including some during busy and on commit edges.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
        end
        idle(8 + 4 * Div);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
